bridge_req_arbiter: RTL and testbench

Round-robin request arbiter and in-order response router that shares one bridge master port among `N_MASTER` requesters. It sits upstream of the bridge request/response block. On the request side it multiplexes one winner per cycle onto the shared port. It records the winner's index in an ID FIFO, then uses that FIFO to steer each returning response back to the requester that issued it. The downstream port returns responses in request order, one or more cycles after grant.

---
 rtl/bridge_arb_pkg.sv | 44 ++++
 rtl/bridge_id_fifo.sv | 86 ++++++++
 rtl/bridge_req_arbiter.sv | 135 +++++++++++++
 tb/tb_bridge_req_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_arb_pkg.sv
// -----------------------------------------------------------------------------
// bridge_arb_pkg
// Shared helpers for the bridge request arbiter:
//   idx_width() - bits needed to index n entries (at least 1)
//   cnt_width() - bits needed to count 0..depth inclusive
//   rr_next()   - round-robin search: first set request at or after ptr,
//                 wrapping modulo n (n need not be a power of two)
// -----------------------------------------------------------------------------
package bridge_arb_pkg;

   // Upper bound on requesters handled by rr_next().
   localparam int unsigned MAX_MASTER   = 32;
   localparam int unsigned MAX_MASTER_W = 5;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Returns the winning index; returns 0 when nothing requests, which the
   // caller masks with its own any-request term.
   function automatic int unsigned rr_next(input logic [MAX_MASTER-1:0] req,
                                           input int unsigned           ptr,
                                           input int unsigned           n);
      int unsigned idx;
      logic        found;
      rr_next = 0;
      found   = 1'b0;
      for (int unsigned k = 0; k < MAX_MASTER; k++) begin
         if ((k < n) && !found) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (req[idx[MAX_MASTER_W-1:0]]) begin
               rr_next = idx;
               found   = 1'b1;
            end
         end
      end
   endfunction

endpackage

// File: rtl/bridge_id_fifo.sv
// -----------------------------------------------------------------------------
// bridge_id_fifo
// Small FIFO of requester IDs with fall-through read of the head entry.
// Pointers wrap at DEPTH (any value >= 1, not only powers of two).
//   clk, rst_n - clock, asynchronous active-low reset
//   push_i     - write data_i (ignored when full)
//   data_i     - ID to store
//   pop_i      - drop the head entry (ignored when empty)
//   data_o     - current head entry, valid while !empty_o
//   full_o     - DEPTH entries held
//   empty_o    - no entries held
// -----------------------------------------------------------------------------
module bridge_id_fifo
   import bridge_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = idx_width(DEPTH);
   localparam int unsigned CNT_W = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   // NOTE: every variable gets a default at the top of the block so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      full_o   = (cnt_q == CNT_W'(DEPTH));
      empty_o  = (cnt_q == '0);
      push_ok  = push_i & ~full_o;
      pop_ok   = pop_i & ~empty_o;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (push_ok && !pop_ok) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: the storage array has no reset; the counter alone decides which
   // entries are meaningful, so clearing the data would only add reset fanout.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/bridge_req_arbiter.sv
// -----------------------------------------------------------------------------
// bridge_req_arbiter
// Round-robin arbiter sharing one bridge master port among N_MASTER
// requesters, with in-order response routing through an ID FIFO.
//   data_*_i (per requester)   - request inputs: req, addr, wen, wdata, be, aux
//   data_gnt_o                 - one-hot grant back to the winner
//   data_r_valid_o             - one-hot response valid to the issuing requester
//   data_r_rdata/opc/aux_o     - response payload, broadcast
//   data_req_o, data_*_o       - winner's request toward the shared port
//   data_gnt_i                 - grant from the shared port
//   data_r_valid_i, data_r_*_i - in-order response from the shared port
//   err_o                      - sticky: a response arrived with nothing
//                                outstanding
// -----------------------------------------------------------------------------
module bridge_req_arbiter
   import bridge_arb_pkg::*;
#(
   parameter int unsigned N_MASTER        = 4,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
   parameter int unsigned AUX_WIDTH       = 8,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   // requester side
   input  logic [N_MASTER-1:0]                  data_req_i,
   input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  data_add_i,
   input  logic [N_MASTER-1:0]                  data_wen_i,
   input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_wdata_i,
   input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    data_be_i,
   input  logic [N_MASTER-1:0][AUX_WIDTH-1:0]   data_aux_i,
   output logic [N_MASTER-1:0]                  data_gnt_o,
   output logic [N_MASTER-1:0]                  data_r_valid_o,
   output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
   output logic                                 data_r_opc_o,
   output logic [AUX_WIDTH-1:0]                 data_r_aux_o,
   // shared port side
   output logic                                 data_req_o,
   output logic [ADDR_WIDTH-1:0]                data_add_o,
   output logic                                 data_wen_o,
   output logic [DATA_WIDTH-1:0]                data_wdata_o,
   output logic [BE_WIDTH-1:0]                  data_be_o,
   output logic [AUX_WIDTH-1:0]                 data_aux_o,
   input  logic                                 data_gnt_i,
   input  logic                                 data_r_valid_i,
   input  logic [DATA_WIDTH-1:0]                data_r_rdata_i,
   input  logic                                 data_r_opc_i,
   input  logic [AUX_WIDTH-1:0]                 data_r_aux_i,
   output logic                                 err_o
);

   localparam int unsigned IDX_W = idx_width(N_MASTER);

   logic [IDX_W-1:0] rr_q, rr_d;
   logic [IDX_W-1:0] winner;
   logic [IDX_W-1:0] head;
   logic             fifo_full, fifo_empty;
   logic             handshake, resp_ok;
   logic             err_q, err_d;

   always_comb begin
      winner = IDX_W'(rr_next(MAX_MASTER'(data_req_i), 32'(rr_q), N_MASTER));
   end

   always_comb begin
      // Blocking on full uses only the registered occupancy, so a pop in the
      // same cycle never opens the request path (no r_valid -> req path).
      data_req_o   = (|data_req_i) & ~fifo_full;
      handshake    = data_req_o & data_gnt_i;

      data_add_o   = '0;
      data_wen_o   = 1'b0;
      data_wdata_o = '0;
      data_be_o    = '0;
      data_aux_o   = '0;
      if (data_req_o) begin
         data_add_o   = data_add_i[winner];
         data_wen_o   = data_wen_i[winner];
         data_wdata_o = data_wdata_i[winner];
         data_be_o    = data_be_i[winner];
         data_aux_o   = data_aux_i[winner];
      end

      data_gnt_o = '0;
      if (handshake) begin
         data_gnt_o[winner] = 1'b1;
      end

      // Explicit wrap so non-power-of-two N_MASTER never reaches an unused code.
      rr_d = rr_q;
      if (handshake) begin
         rr_d = (winner == IDX_W'(N_MASTER - 1)) ? '0 : winner + 1'b1;
      end

      resp_ok        = data_r_valid_i & ~fifo_empty;
      data_r_valid_o = '0;
      if (resp_ok) begin
         data_r_valid_o[head] = 1'b1;
      end

      err_d = err_q | (data_r_valid_i & fifo_empty);
   end

   assign data_r_rdata_o = data_r_rdata_i;
   assign data_r_opc_o   = data_r_opc_i;
   assign data_r_aux_o   = data_r_aux_i;
   assign err_o          = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q  <= '0;
         err_q <= 1'b0;
      end else begin
         rr_q  <= rr_d;
         err_q <= err_d;
      end
   end

   bridge_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (IDX_W)
   ) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (handshake),
      .data_i  (winner),
      .pop_i   (resp_ok),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_bridge_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bridge_req_arbiter
// Instance A: N_MASTER=4, MAX_OUTSTANDING=4, compared every cycle against a
// queue-based reference model. Instance B: N_MASTER=3 for the non-power-of-two
// wrap of the priority pointer.
// -----------------------------------------------------------------------------
module tb_bridge_req_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // ---------------- instance A (4 requesters, depth 4) ----------------
   logic [3:0]        req_a, wen_a;
   logic [3:0][31:0]  add_a, wdata_a;
   logic [3:0][3:0]   be_a;
   logic [3:0][7:0]   aux_a;
   logic [3:0]        gnt_oa, rv_oa;
   logic [31:0]       rdata_oa, add_oa, wdata_oa;
   logic              opc_oa, req_oa, wen_oa, err_a;
   logic [7:0]        raux_oa, aux_oa;
   logic [3:0]        be_oa;
   logic              gnt_ia, rv_ia, opc_ia;
   logic [31:0]       rdata_ia;
   logic [7:0]        raux_ia;

   bridge_req_arbiter #(
      .N_MASTER(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4),
      .AUX_WIDTH(8), .MAX_OUTSTANDING(4)
   ) dut_a (
      .clk(clk), .rst_n(rst_n),
      .data_req_i(req_a), .data_add_i(add_a), .data_wen_i(wen_a),
      .data_wdata_i(wdata_a), .data_be_i(be_a), .data_aux_i(aux_a),
      .data_gnt_o(gnt_oa), .data_r_valid_o(rv_oa), .data_r_rdata_o(rdata_oa),
      .data_r_opc_o(opc_oa), .data_r_aux_o(raux_oa),
      .data_req_o(req_oa), .data_add_o(add_oa), .data_wen_o(wen_oa),
      .data_wdata_o(wdata_oa), .data_be_o(be_oa), .data_aux_o(aux_oa),
      .data_gnt_i(gnt_ia), .data_r_valid_i(rv_ia), .data_r_rdata_i(rdata_ia),
      .data_r_opc_i(opc_ia), .data_r_aux_i(raux_ia), .err_o(err_a)
   );

   // ---------------- instance B (3 requesters, depth 2) ----------------
   logic [2:0]        req_b, wen_b;
   logic [2:0][31:0]  add_b, wdata_b;
   logic [2:0][3:0]   be_b;
   logic [2:0][7:0]   aux_b;
   logic [2:0]        gnt_ob, rv_ob;
   logic [31:0]       rdata_ob, add_ob, wdata_ob;
   logic              opc_ob, req_ob, wen_ob, err_b;
   logic [7:0]        raux_ob, aux_ob;
   logic [3:0]        be_ob;
   logic              gnt_ib, rv_ib;

   bridge_req_arbiter #(
      .N_MASTER(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4),
      .AUX_WIDTH(8), .MAX_OUTSTANDING(2)
   ) dut_b (
      .clk(clk), .rst_n(rst_n),
      .data_req_i(req_b), .data_add_i(add_b), .data_wen_i(wen_b),
      .data_wdata_i(wdata_b), .data_be_i(be_b), .data_aux_i(aux_b),
      .data_gnt_o(gnt_ob), .data_r_valid_o(rv_ob), .data_r_rdata_o(rdata_ob),
      .data_r_opc_o(opc_ob), .data_r_aux_o(raux_ob),
      .data_req_o(req_ob), .data_add_o(add_ob), .data_wen_o(wen_ob),
      .data_wdata_o(wdata_ob), .data_be_o(be_ob), .data_aux_o(aux_ob),
      .data_gnt_i(gnt_ib), .data_r_valid_i(rv_ib), .data_r_rdata_i(32'h0),
      .data_r_opc_i(1'b0), .data_r_aux_i(8'h0), .err_o(err_b)
   );

   // ---------------- reference model for A ----------------
   int rr_m;        // next requester with top priority
   int q_m[$];      // indices of granted, not yet answered requests
   bit err_m;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic idle_a();
      req_a = '0; wen_a = '0; add_a = '0; wdata_a = '0; be_a = '0; aux_a = '0;
      gnt_ia = 1'b0; rv_ia = 1'b0; opc_ia = 1'b0; rdata_ia = '0; raux_ia = '0;
   endtask

   task automatic rand_payload_a();
      for (int i = 0; i < 4; i++) begin
         add_a[i]   = $urandom;
         wdata_a[i] = $urandom;
         be_a[i]    = 4'($urandom);
         aux_a[i]   = 8'($urandom);
         wen_a[i]   = 1'($urandom);
      end
      rdata_ia = $urandom;
      opc_ia   = 1'($urandom);
      raux_ia  = 8'($urandom);
   endtask

   // Called just after a falling edge with A's inputs applied. Checks the
   // combinational outputs, then advances the model across the rising edge.
   task automatic cycle_a(input string tag);
      bit         found, full, ereq, hs;
      int         w;
      logic [3:0] eg, erv;
      found = 0;
      w     = 0;
      for (int k = 0; k < 4; k++) begin
         if (!found && req_a[(rr_m + k) % 4]) begin
            w     = (rr_m + k) % 4;
            found = 1;
         end
      end
      full = (q_m.size() == 4);
      ereq = found && !full;
      hs   = ereq && gnt_ia;
      eg   = hs ? 4'(1 << w) : 4'h0;
      erv  = (rv_ia && q_m.size() > 0) ? 4'(1 << q_m[0]) : 4'h0;
      #1;
      check({tag, " req_o"},   64'(req_oa),   64'(ereq));
      check({tag, " gnt_o"},   64'(gnt_oa),   64'(eg));
      check({tag, " add_o"},   64'(add_oa),   ereq ? 64'(add_a[w])   : 64'h0);
      check({tag, " wen_o"},   64'(wen_oa),   ereq ? 64'(wen_a[w])   : 64'h0);
      check({tag, " wdata_o"}, 64'(wdata_oa), ereq ? 64'(wdata_a[w]) : 64'h0);
      check({tag, " be_o"},    64'(be_oa),    ereq ? 64'(be_a[w])    : 64'h0);
      check({tag, " aux_o"},   64'(aux_oa),   ereq ? 64'(aux_a[w])   : 64'h0);
      check({tag, " r_valid"}, 64'(rv_oa),    64'(erv));
      check({tag, " r_data"},  64'({opc_oa, raux_oa, rdata_oa}),
                               64'({opc_ia, raux_ia, rdata_ia}));
      check({tag, " err"},     64'(err_a),    64'(err_m));
      @(posedge clk);
      if (rv_ia) begin
         if (q_m.size() > 0) void'(q_m.pop_front());
         else                err_m = 1;
      end
      if (hs) begin
         q_m.push_back(w);
         rr_m = (w + 1) % 4;
      end
      @(negedge clk);
   endtask

   // Asserts reset at a falling edge, checks idle outputs, releases a cycle later.
   task automatic do_reset();
      rst_n = 1'b0;
      idle_a();
      rr_m = 0; q_m.delete(); err_m = 0;
      #1;
      check("rst outputs_a", 64'({req_oa, gnt_oa, rv_oa, err_a, add_oa, wen_oa}), 64'h0);
      check("rst outputs_b", 64'({req_ob, gnt_ob, rv_ob, err_b}), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] seq_gnt [5];
      logic [2:0] b_gnt [5];
      logic [2:0] b_rv  [6];
      seq_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      b_gnt   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
      b_rv    = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

      rst_n = 1'b0;
      idle_a();
      req_b = '0; wen_b = '0; add_b = '0; wdata_b = '0; be_b = '0; aux_b = '0;
      gnt_ib = 1'b0; rv_ib = 1'b0;
      @(negedge clk);
      do_reset();

      // All four requesting, granted every cycle, answered one cycle later.
      for (int c = 0; c < 6; c++) begin
         req_a  = (c < 5) ? 4'hF : 4'h0;
         gnt_ia = 1'b1;
         rv_ia  = (c > 0);
         rand_payload_a();
         #1;
         if (c < 5) check("rr order gnt", 64'(gnt_oa), 64'(seq_gnt[c]));
         if (c > 0) check("rr order route", 64'(rv_oa), 64'(seq_gnt[c-1]));
         cycle_a("rr");
      end

      // Grant withheld: no grant, no push, pointer holds.
      idle_a();
      req_a = 4'b1000; gnt_ia = 1'b0;
      cycle_a("nogrant");
      req_a = 4'hF; gnt_ia = 1'b1;     // pointer still at 1 after the rr run
      #1 check("nogrant ptr held", 64'(gnt_oa), 64'(4'b0010));
      cycle_a("nogrant next");
      idle_a(); rv_ia = 1'b1;
      cycle_a("nogrant drain");
      idle_a(); rv_ia = 1'b1;          // nothing outstanding: no push happened
      #1 check("nogrant no push", 64'(rv_oa), 64'h0);
      cycle_a("nogrant empty resp");
      do_reset();

      // FIFO full: four grants, block, pop does not reopen in the same cycle.
      for (int c = 0; c < 7; c++) begin
         idle_a();
         req_a  = 4'b0010;
         gnt_ia = 1'b1;
         rv_ia  = (c == 5);
         rand_payload_a();
         #1;
         check("full req_o", 64'(req_oa), 64'((c < 4) || (c == 6)));
         if (c == 5) check("full route", 64'(rv_oa), 64'(4'b0010));
         cycle_a("full");
      end
      for (int c = 0; c < 4; c++) begin
         idle_a(); rv_ia = 1'b1; rand_payload_a();
         cycle_a("full drain");
      end

      // Randomized legal traffic.
      for (int c = 0; c < 400; c++) begin
         idle_a();
         rand_payload_a();
         req_a  = 4'($urandom);
         gnt_ia = ($urandom_range(0, 3) != 0);
         rv_ia  = (q_m.size() > 0) && ($urandom_range(0, 1) == 1);
         cycle_a("rnd");
      end
      while (q_m.size() > 0) begin
         idle_a(); rv_ia = 1'b1;
         cycle_a("rnd drain");
      end

      // Response with nothing outstanding: dropped, error sticks.
      idle_a(); rv_ia = 1'b1;
      #1 check("orphan r_valid", 64'(rv_oa), 64'h0);
      cycle_a("orphan");
      check("orphan err set", 64'(err_a), 64'h1);
      for (int c = 0; c < 40; c++) begin
         idle_a();
         rand_payload_a();
         req_a  = 4'($urandom);
         gnt_ia = 1'($urandom);
         rv_ia  = (q_m.size() > 0) && ($urandom_range(0, 1) == 1);
         cycle_a("err sticky");
      end
      check("err still set", 64'(err_a), 64'h1);

      // Reset with requests outstanding discards them.
      idle_a(); req_a = 4'b0101; gnt_ia = 1'b1;
      cycle_a("pre reset");
      do_reset();
      check("err cleared", 64'(err_a), 64'h0);
      idle_a(); rv_ia = 1'b1;
      #1 check("post reset r_valid", 64'(rv_oa), 64'h0);
      cycle_a("post reset resp");
      check("post reset err", 64'(err_a), 64'h1);
      idle_a();

      // Instance B: three requesters, wrap from 2 back to 0.
      for (int c = 0; c < 6; c++) begin
         req_b  = (c < 5) ? 3'b111 : 3'b000;
         gnt_ib = 1'b1;
         rv_ib  = (c > 0);
         #1;
         if (c < 5) check("n3 gnt", 64'(gnt_ob), 64'(b_gnt[c]));
         check("n3 route", 64'(rv_ob), 64'(b_rv[c]));
         @(negedge clk);
      end
      req_b = '0; gnt_ib = 1'b0; rv_ib = 1'b0;
      #1 check("n3 err", 64'(err_b), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
